// File: rtl/spec_free_list.sv
// Speculative free list of physical register IDs: a circular buffer with a
// four-wide zero-latency allocate port, a four-wide compacting release port and recovery.
module spec_free_list #(
  parameter int SIZE_PHYSICAL_TABLE = 96,
  parameter int SIZE_PHYSICAL_LOG   = 7,
  parameter int SIZE_RMT            = 32,
  parameter int SIZE_FREE_LIST      = 64,
  parameter int SIZE_FREE_LIST_LOG  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    reqValid_i,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg3_o,
  output logic                          freeListStall_o,
  output logic [SIZE_FREE_LIST_LOG:0]   freeCount_o,
  input  logic                          releasedValid0_i,
  input  logic                          releasedValid1_i,
  input  logic                          releasedValid2_i,
  input  logic                          releasedValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
  input  logic                          recoverFlag_i
);

  localparam int PW         = SIZE_FREE_LIST_LOG;
  localparam int CW         = SIZE_FREE_LIST_LOG + 1;
  localparam int IW         = SIZE_PHYSICAL_LOG;
  localparam int FREE_DEPTH = SIZE_PHYSICAL_TABLE - SIZE_RMT;

  logic [IW-1:0] r_list [SIZE_FREE_LIST];
  logic [PW-1:0] r_head_ptr;
  logic [PW-1:0] r_tail_ptr;
  logic [CW-1:0] r_free_count;

  logic [3:0]    w_rel_valid;
  logic [IW-1:0] w_rel_id   [4];
  logic [PW-1:0] w_wr_idx   [4];
  logic [PW-1:0] w_rd_idx   [4];
  logic [2:0]    w_req_cnt;
  logic [2:0]    w_alloc_cnt;
  logic [2:0]    w_rel_cnt;
  logic [PW-1:0] w_head_next;
  logic [PW-1:0] w_tail_next;
  logic [CW-1:0] w_count_next;

  assign w_rel_valid = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign w_rel_id[0] = releasedPhyMap0_i;
  assign w_rel_id[1] = releasedPhyMap1_i;
  assign w_rel_id[2] = releasedPhyMap2_i;
  assign w_rel_id[3] = releasedPhyMap3_i;

  assign freeListStall_o = (r_free_count < CW'(4));
  assign freeCount_o     = r_free_count;

  // Pointers are PW bits wide, so plain addition wraps modulo the list depth.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rd_idx[k] = r_head_ptr + PW'(k);
    end
  end

  assign freePhyReg0_o = r_list[w_rd_idx[0]];
  assign freePhyReg1_o = r_list[w_rd_idx[1]];
  assign freePhyReg2_o = r_list[w_rd_idx[2]];
  assign freePhyReg3_o = r_list[w_rd_idx[3]];

  always_comb begin
    w_req_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      w_req_cnt = w_req_cnt + 3'(reqValid_i[k]);
    end
    // A stalled list grants nothing, even a request small enough to fit.
    w_alloc_cnt = (freeListStall_o || recoverFlag_i) ? 3'd0 : w_req_cnt;

    // Compact valid release lanes onto consecutive slots starting at the tail.
    w_rel_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      w_wr_idx[k] = r_tail_ptr + PW'(w_rel_cnt);
      w_rel_cnt   = w_rel_cnt + 3'(w_rel_valid[k]);
    end
    w_tail_next = r_tail_ptr + PW'(w_rel_cnt);

    // On recovery the in-flight slots [tail, head) are handed back by
    // pulling the head back onto the tail.
    if (recoverFlag_i) begin
      w_head_next  = w_tail_next;
      w_count_next = CW'(FREE_DEPTH);
    end else begin
      w_head_next  = r_head_ptr + PW'(w_alloc_cnt);
      w_count_next = r_free_count - CW'(w_alloc_cnt) + CW'(w_rel_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        r_list[i] <= IW'(SIZE_RMT + i);
      end
      r_head_ptr   <= '0;
      r_tail_ptr   <= '0;
      r_free_count <= CW'(FREE_DEPTH);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_rel_valid[k]) begin
          r_list[w_wr_idx[k]] <= w_rel_id[k];
        end
      end
      r_head_ptr   <= w_head_next;
      r_tail_ptr   <= w_tail_next;
      r_free_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: a table of per-cycle stimulus with the
// hand-derived outputs expected before each clock edge.
module tb_spec_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] reqValid_i;
  logic [6:0] freePhyReg0_o, freePhyReg1_o, freePhyReg2_o, freePhyReg3_o;
  logic       freeListStall_o;
  logic [6:0] freeCount_o;
  logic       releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
  logic [6:0] releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i;
  logic       recoverFlag_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spec_free_list dut (
    .clk               (clk),
    .reset             (reset),
    .reqValid_i        (reqValid_i),
    .freePhyReg0_o     (freePhyReg0_o),
    .freePhyReg1_o     (freePhyReg1_o),
    .freePhyReg2_o     (freePhyReg2_o),
    .freePhyReg3_o     (freePhyReg3_o),
    .freeListStall_o   (freeListStall_o),
    .freeCount_o       (freeCount_o),
    .releasedValid0_i  (releasedValid0_i),
    .releasedValid1_i  (releasedValid1_i),
    .releasedValid2_i  (releasedValid2_i),
    .releasedValid3_i  (releasedValid3_i),
    .releasedPhyMap0_i (releasedPhyMap0_i),
    .releasedPhyMap1_i (releasedPhyMap1_i),
    .releasedPhyMap2_i (releasedPhyMap2_i),
    .releasedPhyMap3_i (releasedPhyMap3_i),
    .recoverFlag_i     (recoverFlag_i)
  );

  typedef struct {
    logic       rst;
    logic       rec;
    logic [3:0] req;
    logic [3:0] rv;
    logic [6:0] rid [4];
    logic [6:0] ep  [4];
    logic [6:0] ecnt;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string tag, input logic rst, input logic rec,
                              input logic [3:0] req, input logic [3:0] rv,
                              input int r0, input int r1, input int r2, input int r3,
                              input int x0, input int x1, input int x2, input int x3,
                              input int cnt);
    vec_t v;
    v.tag = tag; v.rst = rst; v.rec = rec; v.req = req; v.rv = rv;
    v.rid[0] = 7'(r0); v.rid[1] = 7'(r1); v.rid[2] = 7'(r2); v.rid[3] = 7'(r3);
    v.ep[0]  = 7'(x0); v.ep[1]  = 7'(x1); v.ep[2]  = 7'(x2); v.ep[3]  = 7'(x3);
    v.ecnt = 7'(cnt);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] b);
    return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
  endfunction

  task automatic drive_idle();
    reset = 1'b0; recoverFlag_i = 1'b0; reqValid_i = 4'b0000;
    {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i} = 4'b0000;
    releasedPhyMap0_i = '0; releasedPhyMap1_i = '0; releasedPhyMap2_i = '0; releasedPhyMap3_i = '0;
  endtask

  initial begin
    // Allocation from reset: 32..35 then 36..39, count 64 -> 60 -> 56.
    add("alloc0", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 32,33,34,35, 64);
    add("alloc1", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 36,37,38,39, 60);
    for (int k = 0; k < 12; k++)
      add("drain", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 40+4*k,41+4*k,42+4*k,43+4*k, 56-4*k);
    add("drain3",  0, 0, 4'b0111, 4'b0000, 0,0,0,0, 88,89,90,91, 8);
    add("drain1a", 0, 0, 4'b0001, 4'b0000, 0,0,0,0, 91,92,93,94, 5);
    add("drain1b", 0, 0, 4'b0001, 4'b0000, 0,0,0,0, 92,93,94,95, 4);
    // Count 3: a single-lane request must not be granted.
    add("stalled", 0, 0, 4'b0001, 4'b0000, 0,0,0,0, 93,94,95,32, 3);
    add("rel13",   0, 0, 4'b0000, 4'b1010, 0,5,0,9, 93,94,95,32, 3);
    add("postrel", 0, 0, 4'b0111, 4'b0000, 0,0,0,0, 93,94,95,5, 5);
    add("order",   0, 0, 4'b0000, 4'b0000, 0,0,0,0, 5,9,34,35, 2);
    // Fill list[2..61] with ID == slot index to walk the tail up to 62.
    add("fill0", 0, 0, 4'b0000, 4'b1111, 2,3,4,5, 5,9,34,35, 2);
    for (int j = 1; j < 15; j++)
      add("fill", 0, 0, 4'b0000, 4'b1111, 2+4*j,3+4*j,4+4*j,5+4*j, 5,9,2,3, 2+4*j);
    add("relwrap", 0, 0, 4'b1111, 4'b1111, 10,11,12,13, 5,9,2,3, 62);
    for (int m = 0; m < 14; m++)
      add("walk", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 4+4*m,5+4*m,6+4*m,7+4*m, 62-4*m);
    add("walk2",   0, 0, 4'b0011, 4'b0000, 0,0,0,0, 60,61,10,11, 6);
    // Head at 62 reads the wrapped releases; simultaneous alloc/release at count 4.
    add("simul",   0, 0, 4'b1111, 4'b1111, 20,21,22,23, 10,11,12,13, 4);
    add("postsim", 1, 0, 4'b0000, 4'b0000, 0,0,0,0, 20,21,22,23, 4);
    for (int k = 0; k < 5; k++)
      add("ralloc", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 32+4*k,33+4*k,34+4*k,35+4*k, 64-4*k);
    add("rrel0",   0, 0, 4'b0000, 4'b1111, 32,33,34,35, 52,53,54,55, 44);
    add("rrel1",   0, 0, 4'b0000, 4'b1111, 36,37,38,39, 52,53,54,55, 48);
    add("recover", 0, 1, 4'b1111, 4'b0101, 40,0,41,0, 52,53,54,55, 52);
    add("recov2",  0, 1, 4'b1111, 4'b0000, 0,0,0,0, 42,43,44,45, 64);
    add("postrec", 0, 0, 4'b1111, 4'b0000, 0,0,0,0, 42,43,44,45, 64);
    add("midrst",  1, 1, 4'b1111, 4'b1111, 1,2,3,4, 46,47,48,49, 60);
    add("afterrst",0, 0, 4'b0000, 4'b0000, 0,0,0,0, 32,33,34,35, 64);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      recoverFlag_i = vecs[i].rec;
      reqValid_i    = vecs[i].req;
      {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i} = vecs[i].rv;
      releasedPhyMap0_i = vecs[i].rid[0];
      releasedPhyMap1_i = vecs[i].rid[1];
      releasedPhyMap2_i = vecs[i].rid[2];
      releasedPhyMap3_i = vecs[i].rid[3];
      #1;
      chk({vecs[i].tag, ".p0"},    i, int'(freePhyReg0_o),   int'(vecs[i].ep[0]));
      chk({vecs[i].tag, ".p1"},    i, int'(freePhyReg1_o),   int'(vecs[i].ep[1]));
      chk({vecs[i].tag, ".p2"},    i, int'(freePhyReg2_o),   int'(vecs[i].ep[2]));
      chk({vecs[i].tag, ".p3"},    i, int'(freePhyReg3_o),   int'(vecs[i].ep[3]));
      chk({vecs[i].tag, ".count"}, i, int'(freeCount_o),     int'(vecs[i].ecnt));
      chk({vecs[i].tag, ".stall"}, i, int'(freeListStall_o), (vecs[i].ecnt < 7'd4) ? 1 : 0);
      if (!vecs[i].rst && !vecs[i].rec) begin
        int nxt;
        nxt = int'(vecs[i].ecnt) + popc(vecs[i].rv)
              - ((vecs[i].ecnt < 7'd4) ? 0 : popc(vecs[i].req));
        checks++;
        if (nxt > 64) begin
          failures++;
          $display("FAIL overflow row %0d: next count %0d exceeds 64", i, nxt);
        end
      end
    end

    @(negedge clk);
    drive_idle();
    #1;
    chk("final.count", 999, int'(freeCount_o), 64);
    chk("final.p0",    999, int'(freePhyReg0_o), 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
